shift_arbiter: RTL and testbench
================================

// Module: shift_arbiter
// PURPOSE
//  Shares one 64-bit BarrelShifter between two requesters:
//    port 0 = EXU ALU shift ops; port 1 = LSU load/store byte-lane aligner.
//  Round-robin arbitration, one transaction in flight, registered result held until consumed.
//  Sits between the requesters and a single BarrelShifter instance (DATA_LEN=64, SHT_LEN=6).
// PARAMETERS
//  DATA_LEN  64  operand/result width, passed to BarrelShifter
//  SHT_LEN   6   shift-amount width, passed to BarrelShifter
// PORTS
//  clk             in   1         single clock; all state updates on rising edge
//  rst             in   1         synchronous, active-high reset
//  req_valid[1:0]  in   2         per-port request valid
//  req_ready[1:0]  out  2         per-port request ready
//  req_din0/1      in   DATA_LEN  operand per port
//  req_shamt0/1    in   SHT_LEN   shift amount per port
//  req_al0/1       in   1         1=arithmetic, 0=logical
//  req_lr0/1       in   1         1=left, 0=right
//  req_trunc0/1    in   1         32-bit (W) op: shamt masked to 5 bits
//  resp_valid[1:0] out  2         per-port result valid
//  resp_ready[1:0] in   2         per-port result accept
//  resp_dout       out  DATA_LEN  result; valid only on the port whose resp_valid is 1
//  flush0          in   1         EXU pipeline flush: kills port-0 work
// BEHAVIOUR
//  State
//   - FSM IDLE/HOLD; owner (1b) = port that owns held result; rr_ptr (1b) = preferred port.
//   - Reset: state=IDLE, rr_ptr=0, owner=0, resp_valid=2'b00, resp_dout=0.
//  Request side
//   - req_ready[p] = grant[p] && (state==IDLE || resp_fire).
//     resp_fire = resp_valid[owner] && resp_ready[owner].
//   - grant: if only one port valid, grant it; if both valid, grant rr_ptr.
//   - req_ready is combinational on req_valid, resp_ready and flush0; never on req_din.
//   - Never both bits set in req_ready.
//  Datapath and latency
//   - Shifter driven by the granted port's fields.
//   - Accept (req_valid&req_ready) at edge N -> resp_dout registered, resp_valid[p]=1 after edge N.
//   - Latency is exactly 1 cycle.
//   - resp_dout is the BarrelShifter output, unmodified. Op map {al,lr}:
//     01 SLL, 00 SRL, 11 SLL, 10 SRA. W-op semantics are owned by the shifter.
//   - The requester performs any sign-extension of W results.
//  Response side and rotation
//   - HOLD: resp_valid[owner] stays 1; resp_dout stays stable until resp_fire.
//   - resp_fire without new accept -> IDLE, resp_valid=0.
//   - resp_fire with same-cycle accept -> stay HOLD with the new owner/result.
//     Back-to-back gives 1 result/cycle.
//   - rr_ptr <= ~granted port on every accept. With both ports continuously valid, grants alternate 0,1,0,1.
//   - No port waits more than one other transaction.
//  flush0
//   - Cycle with flush0=1: req_ready[0]=0, so no port-0 accept.
//   - If HOLD with owner=0: result dropped at edge.
//     Then resp_valid[0]=0 and state=IDLE, unless port 1 is accepted in the same cycle.
//     port-1 accept is allowed when port 1 is valid.
//   - Port-1 request, or a result held for port 1, is unaffected.
//   - flush0 together with resp_ready[0]=1: flush wins; the result counts as dropped, not delivered.
//  Reset mid-operation
//   - rst overrides everything at the edge; held result lost; rr_ptr=0.
//   - req_ready = 0 while rst=1.
// TESTING
//  1. req_valid=01, din0=0x8000_0000_0000_0001, shamt0=4, {al,lr}=10, trunc=0
//     -> next cycle resp_valid=01, dout=0xF800_0000_0000_0000.
//  2. Both valid, held, resp_ready=11, 6 cycles -> grants 0,1,0,1,0,1; one result per cycle after first.
//  3. Port 1 result, resp_ready[1]=0 for 3 cycles
//     -> dout stable, req_ready=00 throughout, accept resumes in the cycle resp_ready[1]=1.
//  4. SLLW din0=0x1, shamt0=0x21, trunc=1, {al,lr}=01 -> dout=0x2 (shamt masked to 1).
//  5. Port-0 result held, flush0=1 with req_valid[1]=1 -> next cycle resp_valid=10; port-0 result never seen.
//  6. rst=1 asserted while HOLD -> next cycle resp_valid=00; first grant after release with both valid goes to port 0.

Source files
------------

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 64-bit barrel shifter between the EXU (port 0)
// and the LSU aligner (port 1); one result in flight, held until its owner accepts it.
module shift_arbiter #(
  parameter int unsigned DATA_LEN = 64,
  parameter int unsigned SHT_LEN  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [DATA_LEN-1:0] req_din0,
  input  logic [DATA_LEN-1:0] req_din1,
  input  logic [SHT_LEN-1:0]  req_shamt0,
  input  logic [SHT_LEN-1:0]  req_shamt1,
  input  logic                req_al0,
  input  logic                req_al1,
  input  logic                req_lr0,
  input  logic                req_lr1,
  input  logic                req_trunc0,
  input  logic                req_trunc1,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [DATA_LEN-1:0] resp_dout,
  input  logic                flush0
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state, state_nxt;
  logic                owner, owner_nxt;
  logic                rr_ptr, rr_ptr_nxt;
  logic [1:0]          resp_valid_nxt;
  logic [DATA_LEN-1:0] resp_dout_nxt;

  logic [1:0]          elig;
  logic                gnt_any, gnt_port;
  logic                drop, resp_fire, slot_free, accept;

  logic [DATA_LEN-1:0] sh_din, sh_dout;
  logic [SHT_LEN-1:0]  sh_amt, sh_amt_eff;
  logic                sh_al, sh_lr, sh_trunc;

  // Arbitration: a flushed port 0 is simply not eligible, so port 1 can take the slot.
  always_comb begin
    elig      = {req_valid[1], req_valid[0] & ~flush0};
    gnt_any   = |elig;
    gnt_port  = (elig == 2'b11) ? rr_ptr : elig[1];
    drop      = (state == HOLD) && !owner && flush0;
    resp_fire = (state == HOLD) && resp_valid[owner] && resp_ready[owner] && !drop;
    slot_free = (state == IDLE) || resp_fire || drop;
    accept    = gnt_any && slot_free && !rst;
    req_ready = accept ? (gnt_port ? 2'b10 : 2'b01) : 2'b00;
  end

  // Shared barrel shifter driven by the granted port.
  always_comb begin
    sh_din     = gnt_port ? req_din1   : req_din0;
    sh_amt     = gnt_port ? req_shamt1 : req_shamt0;
    sh_al      = gnt_port ? req_al1    : req_al0;
    sh_lr      = gnt_port ? req_lr1    : req_lr0;
    sh_trunc   = gnt_port ? req_trunc1 : req_trunc0;
    sh_amt_eff = sh_trunc ? (sh_amt & SHT_LEN'(31)) : sh_amt;
    unique case ({sh_al, sh_lr})
      2'b10:   sh_dout = $unsigned($signed(sh_din) >>> sh_amt_eff);
      2'b00:   sh_dout = sh_din >> sh_amt_eff;
      default: sh_dout = sh_din << sh_amt_eff;
    endcase
  end

  // Next-state: a new accept always replaces whatever result is leaving.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    rr_ptr_nxt     = rr_ptr;
    resp_valid_nxt = resp_valid;
    resp_dout_nxt  = resp_dout;
    if (accept) begin
      state_nxt      = HOLD;
      owner_nxt      = gnt_port;
      rr_ptr_nxt     = ~gnt_port;
      resp_valid_nxt = gnt_port ? 2'b10 : 2'b01;
      resp_dout_nxt  = sh_dout;
    end else if (resp_fire || drop) begin
      state_nxt      = IDLE;
      resp_valid_nxt = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      resp_valid <= 2'b00;
      resp_dout  <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      rr_ptr     <= rr_ptr_nxt;
      resp_valid <= resp_valid_nxt;
      resp_dout  <= resp_dout_nxt;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: transaction-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [63:0] req_din0, req_din1, resp_dout;
  logic [5:0]  req_shamt0, req_shamt1;
  logic        req_al0, req_al1, req_lr0, req_lr1, req_trunc0, req_trunc1;
  logic        flush0;

  int checks = 0;
  int errors = 0;

  shift_arbiter #(.DATA_LEN(64), .SHT_LEN(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .req_shamt0(req_shamt0), .req_shamt1(req_shamt1),
    .req_al0(req_al0), .req_al1(req_al1),
    .req_lr0(req_lr0), .req_lr1(req_lr1),
    .req_trunc0(req_trunc0), .req_trunc1(req_trunc1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_dout(resp_dout), .flush0(flush0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference shift as repeated single-bit steps.
  function automatic logic [63:0] shift_ref(input logic [63:0] din, input logic [5:0] shamt,
                                            input bit al, input bit lr, input bit trunc);
    int n;
    logic [63:0] r;
    n = trunc ? int'(shamt) % 32 : int'(shamt);
    r = din;
    for (int k = 0; k < n; k++) begin
      if (lr)      r = r * 64'd2;
      else if (al) r = (r / 64'd2) + (r[63] ? 64'h8000_0000_0000_0000 : 64'd0);
      else         r = r / 64'd2;
    end
    return r;
  endfunction

  // Model: at most one held result, who owns it, and whose turn it is.
  bit          m_live = 1'b0;
  bit          m_held = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_pref = 1'b0;
  logic [63:0] m_data = '0;

  function automatic void model_grant(output bit any, output bit port);
    bit v0, v1, free;
    v0   = req_valid[0] && !flush0;
    v1   = req_valid[1];
    free = !m_held || (!m_owner && flush0) || (resp_ready[m_owner] && !(!m_owner && flush0));
    any  = (v0 || v1) && free && !rst;
    port = (v0 && v1) ? m_pref : v1;
  endfunction

  always @(posedge clk) begin
    bit any, port;
    if (rst) begin
      m_live = 1'b1;
      m_held = 1'b0;
      m_pref = 1'b0;
    end else if (m_live) begin
      model_grant(any, port);
      if (any) begin
        m_data  = port ? shift_ref(req_din1, req_shamt1, req_al1, req_lr1, req_trunc1)
                       : shift_ref(req_din0, req_shamt0, req_al0, req_lr0, req_trunc0);
        m_held  = 1'b1;
        m_owner = port;
        m_pref  = !port;
      end else if (m_held && ((!m_owner && flush0) || resp_ready[m_owner])) begin
        m_held = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    bit any, port;
    logic [1:0] exp_rdy, exp_rv;
    if (m_live) begin
      model_grant(any, port);
      exp_rdy = any ? (port ? 2'b10 : 2'b01) : 2'b00;
      exp_rv  = m_held ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      check("model req_ready", 64'(req_ready), 64'(exp_rdy));
      check("model resp_valid", 64'(resp_valid), 64'(exp_rv));
      if (m_held) check("model resp_dout", resp_dout, m_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00; flush0 = 1'b0;
    req_din0 = '0; req_din1 = '0; req_shamt0 = '0; req_shamt1 = '0;
    req_al0 = 1'b0; req_al1 = 1'b0; req_lr0 = 1'b0; req_lr1 = 1'b0;
    req_trunc0 = 1'b0; req_trunc1 = 1'b0;
    cyc(); cyc();
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset resp_dout", resp_dout, 64'd0);
    req_valid = 2'b11; #1;
    check("ready low in reset", 64'(req_ready), 64'd0);
    req_valid = 2'b00;
    rst = 1'b0;
    cyc();

    // SRA of a negative operand
    req_valid = 2'b01; req_din0 = 64'h8000_0000_0000_0001; req_shamt0 = 6'd4;
    req_al0 = 1'b1; req_lr0 = 1'b0; #1;
    check("t1 req_ready", 64'(req_ready), 64'h1);
    cyc();
    req_valid = 2'b00;
    check("t1 resp_valid", 64'(resp_valid), 64'h1);
    check("t1 dout", resp_dout, 64'hF800_0000_0000_0000);
    resp_ready = 2'b01;
    cyc();
    check("t1 drained", 64'(resp_valid), 64'h0);

    // SLLW: shamt 0x21 masked to 1
    req_valid = 2'b01; req_din0 = 64'h1; req_shamt0 = 6'h21; req_trunc0 = 1'b1;
    req_al0 = 1'b0; req_lr0 = 1'b1; resp_ready = 2'b11;
    cyc();
    req_valid = 2'b00;
    check("t4 dout", resp_dout, 64'h2);
    cyc();

    // Port-1 result held under backpressure
    req_valid = 2'b10; req_din1 = 64'hABCD; req_shamt1 = 6'd8; req_lr1 = 1'b1;
    resp_ready = 2'b00;
    cyc();
    req_din0 = 64'h10; req_shamt0 = 6'd1; req_trunc0 = 1'b0; req_lr0 = 1'b1; req_al0 = 1'b0;
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3 ready stalled", 64'(req_ready), 64'h0);
      cyc();
      check("t3 dout stable", resp_dout, 64'hAB_CD00);
      check("t3 valid held", 64'(resp_valid), 64'h2);
    end

    // Resume, then alternate grants with both ports valid
    resp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t2 grant", 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
      cyc();
      check("t2 resp_valid", 64'(resp_valid), (i % 2 == 0) ? 64'h1 : 64'h2);
      check("t2 dout", resp_dout, (i % 2 == 0) ? 64'h20 : 64'hAB_CD00);
    end
    req_valid = 2'b00;
    cyc();

    // Flush drops port-0 result while port 1 takes the slot
    req_valid = 2'b01; req_din0 = 64'h5; req_shamt0 = 6'd0; req_lr0 = 1'b0;
    resp_ready = 2'b00;
    cyc();
    req_valid = 2'b10; flush0 = 1'b1; req_din1 = 64'hF0; req_shamt1 = 6'd4;
    req_lr1 = 1'b0; req_al1 = 1'b0; #1;
    check("t5 ready", 64'(req_ready), 64'h2);
    cyc();
    check("t5 resp_valid", 64'(resp_valid), 64'h2);
    check("t5 dout", resp_dout, 64'hF);
    flush0 = 1'b0; req_valid = 2'b00; resp_ready = 2'b10;
    cyc();

    // Flush beats resp_ready[0]
    req_valid = 2'b01; resp_ready = 2'b00;
    cyc();
    flush0 = 1'b1; resp_ready = 2'b01; #1;
    check("flush ready", 64'(req_ready), 64'h0);
    cyc();
    check("flush dropped", 64'(resp_valid), 64'h0);
    flush0 = 1'b0; req_valid = 2'b00;
    cyc();

    // Reset while holding; arbitration restarts at port 0
    req_valid = 2'b01; resp_ready = 2'b00;
    cyc();
    rst = 1'b1; req_valid = 2'b11;
    cyc();
    check("t6 reset valid", 64'(resp_valid), 64'h0);
    rst = 1'b0; #1;
    check("t6 first grant", 64'(req_ready), 64'h1);
    cyc();
    check("t6 resp_valid", 64'(resp_valid), 64'h1);
    check("t6 dout", resp_dout, 64'h5);
    req_valid = 2'b00; resp_ready = 2'b11;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
